// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register/data width defaults and the
// forwarding-scoreboard entry that tracks one in-flight register write.
package cpu_types_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_RW = 5;

  typedef struct packed {
    logic              valid;
    logic [DEF_RW-1:0] dst;
    logic [DEF_DW-1:0] data;
    logic              data_ok;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port priority search over the tracked older stages; the youngest
// matching producer wins and decides forward / bypass-load / stall.
module fwd_port_match
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = DEF_DW,
  parameter int RW    = DEF_RW
) (
  input  fwd_entry_t        entries [DEPTH],
  input  logic [RW-1:0]     rd_addr,
  input  logic              ld_valid,
  input  logic [DW-1:0]     ld_data,
  output logic              fwd_en,
  output logic [DW-1:0]     fwd_data,
  output logic              stall_req
);

  logic       found;
  logic       win_is_e1;
  fwd_entry_t win;

  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_is_e1 = 1'b0;
    fwd_en    = 1'b0;
    fwd_data  = '0;
    stall_req = 1'b0;

    // Walk oldest to youngest so the youngest match overwrites the others.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries[k].valid && (entries[k].dst == rd_addr) && (rd_addr != '0)) begin
        found     = 1'b1;
        win       = entries[k];
        win_is_e1 = (k == 0);
      end
    end

    if (found) begin
      if (win.data_ok) begin
        fwd_en   = 1'b1;
        fwd_data = win.data;
      end else if (win_is_e1 && ld_valid) begin
        fwd_en   = 1'b1;
        fwd_data = ld_data;
      end else begin
        stall_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Tracks the last DEPTH register producers behind EX and resolves operand
// forwarding and load-use stalls for NPORT consumer read ports.
module forwarding_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int RW    = DEF_RW,
  parameter int NPORT = 2,
  parameter int DEPTH = 2
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      advance,
  input  logic                      flush,
  input  logic                      prod_wen,
  input  logic [RW-1:0]             prod_dst,
  input  logic                      prod_is_load,
  input  logic [DW-1:0]             prod_data,
  input  logic                      ld_valid,
  input  logic [DW-1:0]             ld_data,
  input  logic [NPORT-1:0][RW-1:0]  rd_addr,
  output logic [NPORT-1:0]          fwd_en,
  output logic [NPORT-1:0][DW-1:0]  fwd_data,
  output logic                      stall,
  output logic [31:0]               stall_cnt
);

  fwd_entry_t       ent_q [DEPTH];
  fwd_entry_t       ent_d [DEPTH];
  logic [NPORT-1:0] port_stall;
  logic             shift;
  logic             ld_fill;

  assign stall   = |port_stall;
  assign shift   = advance & ~stall;
  assign ld_fill = ld_valid & ent_q[0].valid & ~ent_q[0].data_ok;

  always_comb begin
    ent_d = ent_q;
    if (shift) begin
      ent_d[0] = '{valid:   prod_wen & ~flush & (prod_dst != '0),
                   dst:     prod_dst,
                   data:    prod_data,
                   data_ok: ~prod_is_load};
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k] = ent_q[k-1];
        // A load returning as its entry moves on lands in the next stage.
        if (k == 1 && ld_fill) begin
          ent_d[k].data    = ld_data;
          ent_d[k].data_ok = 1'b1;
        end
      end
    end else if (ld_fill) begin
      ent_d[0].data    = ld_data;
      ent_d[0].data_ok = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      // NOTE: the entry array is small control state, so it is fully cleared
      // on reset rather than left uninitialised like a RAM would be.
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
      stall_cnt <= '0;
    end else begin
      ent_q <= ent_d;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_port_match #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .RW    (RW)
    ) u_match (
      .entries   (ent_q),
      .rd_addr   (rd_addr[p]),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .fwd_en    (fwd_en[p]),
      .fwd_data  (fwd_data[p]),
      .stall_req (port_stall[p])
    );
  end

endmodule
